// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//   Shares one SDRAM port between two cache controllers. A granted requester
//   owns the port for a whole block transfer: one setup cycle plus one strobe
//   cycle per word, followed by a one-cycle done pulse. Ties are broken
//   round-robin against the requester served last.
//
// Ports
//   clk                  clock, all state changes on the rising edge
//   rst                  asynchronous reset, active low
//   req0/req1            block-transfer request from controller 0/1
//   wr_rd0/wr_rd1        1 = write block to SDRAM, 0 = read block
//   blk_addr0/blk_addr1  block address of each requester
//   gnt0/gnt1            port ownership
//   done0/done1          one-cycle transfer-complete pulse
//   mem_addr             {latched block address, word offset}
//   mem_wr_rd            latched direction of the owner
//   memstrb              per-word SDRAM strobe
//   addr_offset_counter  current word offset within the block
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int BLOCKSIZE_W = 4,
    parameter int ADDR_W      = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0,
    input  logic                          req1,
    input  logic                          wr_rd0,
    input  logic                          wr_rd1,
    input  logic [ADDR_W-BLOCKSIZE_W-1:0] blk_addr0,
    input  logic [ADDR_W-BLOCKSIZE_W-1:0] blk_addr1,
    output logic                          gnt0,
    output logic                          gnt1,
    output logic                          done0,
    output logic                          done1,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_wr_rd,
    output logic                          memstrb,
    output logic [BLOCKSIZE_W-1:0]        addr_offset_counter
);

    localparam int BLK_W = ADDR_W - BLOCKSIZE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   gnt0_q, gnt0_d;
    logic                   gnt1_q, gnt1_d;
    logic                   done0_q, done0_d;
    logic                   done1_q, done1_d;
    logic                   last_q, last_d;      // 1 = controller 1 served last
    logic                   wr_q, wr_d;
    logic [BLK_W-1:0]       blk_q, blk_d;
    logic [BLOCKSIZE_W-1:0] off_q, off_d;
    logic                   strb_q, strb_d;
    logic                   win1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            blk_q   <= '0;
            off_q   <= '0;
            strb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            blk_q   <= blk_d;
            off_q   <= off_d;
            strb_q  <= strb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        last_d  = last_q;
        wr_d    = wr_q;
        blk_d   = blk_q;
        off_d   = off_q;
        strb_d  = strb_q;
        // With a single requester it wins outright; on a tie the one not
        // served last wins.
        win1    = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt0_d  = ~win1;
                    gnt1_d  = win1;
                    wr_d    = win1 ? wr_rd1 : wr_rd0;
                    blk_d   = win1 ? blk_addr1 : blk_addr0;
                    off_d   = '0;
                    strb_d  = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!strb_q) begin
                    strb_d = 1'b1;
                end else if (!(&off_q)) begin
                    off_d  = off_q + 1'b1;
                    strb_d = 1'b0;
                end else begin
                    // Last word strobed: hold the offset, raise the owner's done.
                    strb_d  = 1'b0;
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                off_d   = '0;
                last_d  = gnt1_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt0                = gnt0_q;
    assign gnt1                = gnt1_q;
    assign done0               = done0_q;
    assign done1               = done1_q;
    assign mem_addr            = {blk_q, off_q};
    assign mem_wr_rd           = wr_q;
    assign memstrb             = strb_q;
    assign addr_offset_counter = off_q;

endmodule
